risc_core_hs: RTL and testbench

Parametrised, handshake-based successor to the fixed 5-bit/8-bit VeriRISC accumulator CPU.
- Executes the same 8-opcode accumulator ISA, with data and address widths set by parameters.
- The fixed 8-phase sequencer is replaced by a state machine that stalls on a req/ack memory bus, so the core works with memories of any latency.
- Adds single-step mode and resume-from-halt.

---
 rtl/risc_pkg.sv | 36 +++
 rtl/risc_alu_p.sv | 26 ++
 rtl/risc_core_hs.sv | 141 ++++++++++++++
 tb/tb_risc_core_hs.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared definitions for the handshake accumulator core: opcodes, FSM states
// and instruction-field helpers usable at any data/address width.
package risc_pkg;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC_RD,
    ST_EXEC_WR,
    ST_PAUSE,
    ST_HALTED
  } state_e;

  // Widest instruction word the helpers accept; callers zero-extend into it.
  localparam int IR_MAX = 64;

  function automatic logic [2:0] opcode_of(input logic [IR_MAX-1:0] ir,
                                           input int dwidth);
    return 3'(ir >> (dwidth - 3));
  endfunction

  function automatic logic [IR_MAX-1:0] operand_of(input logic [IR_MAX-1:0] ir,
                                                   input int awidth);
    return ir & ((IR_MAX'(1) << awidth) - IR_MAX'(1));
  endfunction

endpackage

// File: rtl/risc_alu_p.sv
// Accumulator ALU: combines the accumulator with a memory operand according
// to the opcode; opcodes without a data result pass the accumulator through.
module risc_alu_p
  import risc_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic [DWIDTH-1:0] acc_i,
  input  logic [DWIDTH-1:0] rdata_i,
  input  logic [2:0]        opcode_i,
  output logic [DWIDTH-1:0] result_o
);

  always_comb begin
    // NOTE: default assigned first so every path drives result_o and no latch is inferred.
    result_o = acc_i;
    case (opcode_i)
      OP_ADD:  result_o = acc_i + rdata_i;
      OP_AND:  result_o = acc_i & rdata_i;
      OP_XOR:  result_o = acc_i ^ rdata_i;
      OP_LDA:  result_o = rdata_i;
      default: result_o = acc_i;
    endcase
  end

endmodule

// File: rtl/risc_core_hs.sv
// Parametrised accumulator CPU with a req/ack memory bus; stalls on any memory
// latency, supports single-step pause and resume from halt.
module risc_core_hs
  import risc_pkg::*;
#(
  parameter int                AWIDTH   = 5,
  parameter int                DWIDTH   = 8,
  parameter logic [AWIDTH-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic              step_mode,
  input  logic              go,
  output logic              halt,
  output logic              retire,
  output logic [AWIDTH-1:0] pc,
  output logic [DWIDTH-1:0] acc
);

  if (DWIDTH < AWIDTH + 3 || DWIDTH > IR_MAX) begin : g_width_check
    $error("risc_core_hs: DWIDTH must be at least AWIDTH+3 and at most IR_MAX");
  end

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [DWIDTH-1:0] acc_q, acc_d;
  logic [DWIDTH-1:0] ir_q, ir_d;
  logic              req_q, req_d;
  logic              retire_d;

  logic [2:0]        opcode;
  logic [AWIDTH-1:0] op_addr;
  logic [DWIDTH-1:0] alu_result;
  logic              xfer;
  state_e            end_state;

  assign opcode    = opcode_of(IR_MAX'(ir_q), DWIDTH);
  assign op_addr   = AWIDTH'(operand_of(IR_MAX'(ir_q), AWIDTH));
  // An ack only counts while our own request is up.
  assign xfer      = req_q & mem_ack;
  assign end_state = step_mode ? ST_PAUSE : ST_FETCH;

  risc_alu_p #(.DWIDTH(DWIDTH)) u_alu (
    .acc_i   (acc_q),
    .rdata_i (mem_rdata),
    .opcode_i(opcode),
    .result_o(alu_result)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    acc_d    = acc_q;
    ir_d     = ir_q;
    retire_d = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (xfer) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (opcode)
          OP_HLT: begin
            retire_d = 1'b1;
            state_d  = ST_HALTED;
          end
          OP_SKZ: begin
            if (acc_q == '0) pc_d = pc_q + 1'b1;
            retire_d = 1'b1;
            state_d  = end_state;
          end
          OP_JMP: begin
            pc_d     = op_addr;
            retire_d = 1'b1;
            state_d  = end_state;
          end
          OP_STO:  state_d = ST_EXEC_WR;
          default: state_d = ST_EXEC_RD;
        endcase
      end
      ST_EXEC_RD: begin
        if (xfer) begin
          acc_d    = alu_result;
          retire_d = 1'b1;
          state_d  = end_state;
        end
      end
      ST_EXEC_WR: begin
        if (xfer) begin
          retire_d = 1'b1;
          state_d  = end_state;
        end
      end
      ST_PAUSE, ST_HALTED: begin
        if (go) state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase

    // Request is registered from the next state so it rises with bus-state entry
    // and is low for the first FETCH cycle after reset.
    req_d = (state_d == ST_FETCH) || (state_d == ST_EXEC_RD) || (state_d == ST_EXEC_WR);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    if (rst) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      acc_q   <= '0;
      ir_q    <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      ir_q    <= ir_d;
      req_q   <= req_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = (state_q == ST_EXEC_WR);
  assign mem_addr  = (state_q == ST_FETCH) ? pc_q : op_addr;
  assign mem_wdata = acc_q;
  assign halt      = (state_q == ST_HALTED);
  assign retire    = retire_d;
  assign pc        = pc_q;
  assign acc       = acc_q;

endmodule

// File: tb/tb_risc_core_hs.sv
// Self-checking bench: directed program scenarios on two core configurations
// plus random programs compared against an instruction-level reference model.
module tb_risc_core_hs;

  localparam logic [2:0] T_HLT = 3'd0, T_SKZ = 3'd1, T_ADD = 3'd2, T_AND = 3'd3;
  localparam logic [2:0] T_XOR = 3'd4, T_LDA = 3'd5, T_STO = 3'd6, T_JMP = 3'd7;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  // ---------------- DUT A: default parameters ----------------
  logic       rst_a = 1'b1, step_a = 1'b0, go_a = 1'b0;
  logic       a_req, a_we, a_halt, a_retire;
  logic       a_ack = 1'b0;
  logic [4:0] a_addr, a_pc;
  logic [7:0] a_wdata, a_acc;
  logic [7:0] a_rdata = 8'h00;

  risc_core_hs u_dut_a (
    .clk(clk), .rst(rst_a), .mem_req(a_req), .mem_we(a_we), .mem_addr(a_addr),
    .mem_wdata(a_wdata), .mem_rdata(a_rdata), .mem_ack(a_ack), .step_mode(step_a),
    .go(go_a), .halt(a_halt), .retire(a_retire), .pc(a_pc), .acc(a_acc)
  );

  // ---------------- DUT B: AWIDTH=8, DWIDTH=12, RESET_PC=0x40 ----------------
  logic        rst_b = 1'b1, step_b = 1'b0, go_b = 1'b0;
  logic        b_req, b_we, b_halt, b_retire;
  logic        b_ack = 1'b0;
  logic [7:0]  b_addr, b_pc;
  logic [11:0] b_wdata, b_acc;
  logic [11:0] b_rdata = 12'h000;

  risc_core_hs #(.AWIDTH(8), .DWIDTH(12), .RESET_PC(8'h40)) u_dut_b (
    .clk(clk), .rst(rst_b), .mem_req(b_req), .mem_we(b_we), .mem_addr(b_addr),
    .mem_wdata(b_wdata), .mem_rdata(b_rdata), .mem_ack(b_ack), .step_mode(step_b),
    .go(go_b), .halt(b_halt), .retire(b_retire), .pc(b_pc), .acc(b_acc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- memory models ----------------
  // Wait cycles = number of request cycles before the ack cycle.
  logic [7:0] ma [32];
  int         a_wcnt = 0, a_waits = 0, a_fixed = 0;
  bit         a_rand = 1'b0;
  logic       a_pend;
  logic [4:0] a_paddr;
  logic       a_pwe;
  logic [7:0] a_pwd;

  always @(posedge clk) begin
    a_pend  = (a_req === 1'b1) && !a_ack && !rst_a;
    a_paddr = a_addr;
    a_pwe   = a_we;
    a_pwd   = a_wdata;
    if ((a_req === 1'b1) && a_ack) begin
      if (a_we) ma[a_addr] = a_wdata;
      a_wcnt  = 0;
      a_waits = a_rand ? int'($urandom_range(0, 3)) : a_fixed;
    end else if (a_req === 1'b1) a_wcnt++;
    else a_wcnt = 0;
    #1;
    if (a_pend && (a_req === 1'b1)) begin
      chk("bus addr stable", a_addr, a_paddr);
      chk("bus we stable", a_we, a_pwe);
      chk("bus wdata stable", a_wdata, a_pwd);
    end
    a_ack   = (a_req === 1'b1) && (a_wcnt >= a_waits);
    a_rdata = a_ack ? ma[a_addr] : 8'($urandom);
  end

  logic [11:0] mb [256];
  int          b_wcnt = 0, b_waits = 0;

  always @(posedge clk) begin
    if ((b_req === 1'b1) && b_ack) begin
      if (b_we) mb[b_addr] = b_wdata;
      b_wcnt = 0;
    end else if (b_req === 1'b1) b_wcnt++;
    else b_wcnt = 0;
    #1;
    b_ack   = (b_req === 1'b1) && (b_wcnt >= b_waits);
    b_rdata = b_ack ? mb[b_addr] : 12'($urandom);
  end

  // ---------------- helpers ----------------
  function automatic logic [7:0] enc_a(input logic [2:0] op, input logic [4:0] a);
    return {op, a};
  endfunction

  function automatic logic [11:0] enc_b(input logic [2:0] op, input logic [7:0] a);
    return {op, 1'b1, a};  // the bit between opcode and operand must be ignored
  endfunction

  task automatic cfg_a(input bit rnd, input int w);
    a_rand  = rnd;
    a_fixed = w;
    a_waits = rnd ? int'($urandom_range(0, 3)) : w;
  endtask

  task automatic clear_a();
    for (int i = 0; i < 32; i++) ma[i] = 8'h00;
  endtask

  task automatic load_t1();
    clear_a();
    ma[0]  = enc_a(T_LDA, 5'd10);
    ma[1]  = enc_a(T_ADD, 5'd11);
    ma[2]  = enc_a(T_STO, 5'd12);
    ma[3]  = enc_a(T_HLT, 5'd0);
    ma[10] = 8'h05;
    ma[11] = 8'hFE;
  endtask

  task automatic reset_a();
    @(negedge clk) rst_a = 1'b1;
    @(negedge clk);
    @(negedge clk) rst_a = 1'b0;
  endtask

  task automatic wait_ret_a(input string tag);
    int n;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (a_retire) break;
    end
    if (n == 200) chk({tag, " retire timeout"}, a_retire, 1'b1);
  endtask

  int nret_a;
  int rt_a[$];

  task automatic run_halt_a(input string tag);
    nret_a = 0;
    rt_a.delete();
    for (int n = 0; n < 400 && !a_halt; n++) begin
      @(negedge clk);
      if (a_retire) begin
        nret_a++;
        rt_a.push_back(cyc);
      end
    end
    chk({tag, " halt"}, a_halt, 1'b1);
  endtask

  // Instruction-level reference model.
  logic [7:0] mm [32];
  logic [4:0] mpc;
  logic [7:0] macc;
  bit         mhalt;

  task automatic model_step();
    logic [7:0] w = mm[mpc];
    logic [4:0] a = w[4:0];
    mpc = mpc + 5'd1;
    case (w[7:5])
      T_HLT: mhalt = 1'b1;
      T_SKZ: if (macc == 8'h00) mpc = mpc + 5'd1;
      T_ADD: macc = macc + mm[a];
      T_AND: macc = macc & mm[a];
      T_XOR: macc = macc ^ mm[a];
      T_LDA: macc = mm[a];
      T_STO: mm[a] = macc;
      T_JMP: mpc = a;
      default: ;
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- 1: zero-wait program, reset state ----
    load_t1();
    cfg_a(1'b0, 0);
    b_waits = 0;
    for (int i = 0; i < 256; i++) mb[i] = 12'h000;
    repeat (2) @(negedge clk);
    chk("reset req", a_req, 1'b0);
    chk("reset we", a_we, 1'b0);
    chk("reset halt", a_halt, 1'b0);
    chk("reset retire", a_retire, 1'b0);
    chk("reset pc", a_pc, 5'd0);
    chk("reset acc", a_acc, 8'h00);
    chk("reset pc B", b_pc, 8'h40);
    chk("reset req B", b_req, 1'b0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    run_halt_a("t1");
    chk("t1 retires", nret_a, 4);
    chk("t1 acc", a_acc, 8'h03);
    chk("t1 pc", a_pc, 5'd4);
    chk("t1 mem12", ma[12], 8'h03);
    chk("t1 gap lda-add", rt_a[1] - rt_a[0], 3);
    chk("t1 gap add-sto", rt_a[2] - rt_a[1], 3);
    chk("t1 gap sto-hlt", rt_a[3] - rt_a[2], 2);

    // ---- 2: ack 3 cycles after the memory registers the request (4 waits) ----
    load_t1();
    cfg_a(1'b0, 4);
    reset_a();
    run_halt_a("t2");
    chk("t2 retires", nret_a, 4);
    chk("t2 acc", a_acc, 8'h03);
    chk("t2 pc", a_pc, 5'd4);
    chk("t2 mem12", ma[12], 8'h03);
    chk("t2 gap lda-add", rt_a[1] - rt_a[0], 11);
    chk("t2 gap add-sto", rt_a[2] - rt_a[1], 11);
    chk("t2 gap sto-hlt", rt_a[3] - rt_a[2], 6);

    // ---- 3: SKZ with acc=0 and acc=1, JMP wrap at pc 31 ----
    cfg_a(1'b0, 0);
    for (int v = 0; v < 2; v++) begin
      clear_a();
      ma[0]  = enc_a(T_LDA, 5'd20);
      ma[1]  = enc_a(T_AND, 5'd20);
      ma[2]  = enc_a(T_SKZ, 5'd0);
      ma[3]  = enc_a(T_HLT, 5'd0);
      ma[4]  = enc_a(T_HLT, 5'd0);
      ma[20] = 8'(v);
      reset_a();
      run_halt_a("t3 skz");
      chk("t3 skz pc", a_pc, (v == 0) ? 5'd5 : 5'd4);
      chk("t3 skz acc", a_acc, 8'(v));
    end
    clear_a();
    ma[0]  = enc_a(T_JMP, 5'd31);
    ma[31] = enc_a(T_JMP, 5'd31);
    reset_a();
    wait_ret_a("t3 jmp0");
    @(negedge clk);
    chk("t3 pc after jmp", a_pc, 5'd31);
    wait_ret_a("t3 jmp31");
    chk("t3 pc wrapped in decode", a_pc, 5'd0);
    @(negedge clk);
    chk("t3 pc reloaded", a_pc, 5'd31);
    chk("t3 refetch req", a_req, 1'b1);
    chk("t3 refetch addr", a_addr, 5'd31);

    // ---- 4: single-step mode ----
    load_t1();
    step_a = 1'b1;
    reset_a();
    for (int i = 0; i < 3; i++) begin
      wait_ret_a("t4 step");
      go_a = 1'b1;  // go in the retiring cycle must be ignored
      @(negedge clk) go_a = 1'b0;
      chk("t4 paused req", a_req, 1'b0);
      chk("t4 pc", a_pc, 5'(i + 1));
      chk("t4 acc", a_acc, (i == 0) ? 8'h05 : 8'h03);
      repeat (2) @(negedge clk);
      chk("t4 still paused", a_req, 1'b0);
      go_a = 1'b1;
      @(negedge clk) go_a = 1'b0;
      chk("t4 fetch req", a_req, 1'b1);
      chk("t4 fetch we", a_we, 1'b0);
      chk("t4 fetch addr", a_addr, 5'(i + 1));
    end
    wait_ret_a("t4 hlt");
    @(negedge clk);
    chk("t4 halt", a_halt, 1'b1);
    chk("t4 mem12", ma[12], 8'h03);
    step_a = 1'b0;

    // ---- 5: halt and resume ----
    clear_a();
    ma[0]  = enc_a(T_JMP, 5'd5);
    ma[5]  = enc_a(T_HLT, 5'd0);
    ma[6]  = enc_a(T_LDA, 5'd10);
    ma[7]  = enc_a(T_HLT, 5'd0);
    ma[10] = 8'h05;
    reset_a();
    wait_ret_a("t5 jmp");
    wait_ret_a("t5 hlt");
    go_a = 1'b1;  // same cycle as entry to HALTED: ignored
    @(negedge clk) go_a = 1'b0;
    chk("t5 halt", a_halt, 1'b1);
    chk("t5 pc", a_pc, 5'd6);
    repeat (3) @(negedge clk);
    chk("t5 still halted", a_halt, 1'b1);
    chk("t5 halted req", a_req, 1'b0);
    go_a = 1'b1;
    @(negedge clk) go_a = 1'b0;
    chk("t5 resume halt", a_halt, 1'b0);
    chk("t5 resume req", a_req, 1'b1);
    chk("t5 resume addr", a_addr, 5'd6);
    run_halt_a("t5 second");
    chk("t5 acc", a_acc, 8'h05);
    chk("t5 final pc", a_pc, 5'd8);

    // ---- 6: wide configuration, XOR, reset during EXEC_RD ----
    for (int i = 0; i < 256; i++) mb[i] = 12'h000;
    mb[8'h40] = enc_b(T_LDA, 8'h80);
    mb[8'h41] = enc_b(T_XOR, 8'h81);
    mb[8'h42] = enc_b(T_STO, 8'h82);
    mb[8'h43] = enc_b(T_HLT, 8'h00);
    mb[8'h44] = enc_b(T_LDA, 8'h80);
    mb[8'h80] = 12'hFFF;
    mb[8'h81] = 12'h0F0;
    b_waits = 2;
    @(negedge clk) rst_b = 1'b1;
    @(negedge clk) rst_b = 1'b0;
    for (int n = 0; n < 200 && !b_halt; n++) @(negedge clk);
    chk("t6 halt", b_halt, 1'b1);
    chk("t6 xor acc", b_acc, 12'hF0F);
    chk("t6 mem82", mb[8'h82], 12'hF0F);
    chk("t6 pc", b_pc, 8'h44);
    go_b = 1'b1;
    @(negedge clk) go_b = 1'b0;
    for (int n = 0; n < 50 && !(b_req && b_addr == 8'h80); n++) @(negedge clk);
    chk("t6 exec_rd addr", b_addr, 8'h80);
    chk("t6 exec_rd we", b_we, 1'b0);
    rst_b = 1'b1;
    @(negedge clk) rst_b = 1'b0;
    chk("t6 req dropped", b_req, 1'b0);
    chk("t6 acc cleared", b_acc, 12'h000);
    chk("t6 pc reloaded", b_pc, 8'h40);
    for (int n = 0; n < 20 && !b_req; n++) @(negedge clk);
    chk("t6 refetch req", b_req, 1'b1);
    chk("t6 refetch addr", b_addr, 8'h40);
    chk("t6 refetch we", b_we, 1'b0);
    chk("t6 refetch acc", b_acc, 12'h000);

    // ---- random programs vs instruction-level model, random wait states ----
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 32; i++) begin
        ma[i] = {3'($urandom_range(1, 7)), 5'($urandom)};
        mm[i] = ma[i];
      end
      cfg_a(1'b1, 0);
      reset_a();
      mpc   = 5'd0;
      macc  = 8'h00;
      mhalt = 1'b0;
      for (int k = 0; k < 60 && !mhalt; k++) begin
        wait_ret_a("rnd");
        @(negedge clk);
        model_step();
        chk("rnd pc", a_pc, mpc);
        chk("rnd acc", a_acc, macc);
        chk("rnd halt", a_halt, mhalt);
      end
      for (int i = 0; i < 32; i++) chk("rnd mem", ma[i], mm[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
